// File: rtl/fwd_hazard_scoreboard_if.sv
// Signal bundle between the pipeline control (master) and the forwarding/hazard unit (slave).
// The pipeline drives every input on the master side. The unit returns the forward selects,
// the stall, the pending count and the timeout pulse on the slave side.
// All of these signals are level signals and use no handshake. The unit samples its inputs
// combinationally, and it updates the scoreboard only at the rising edge of iClk.
interface fwd_hazard_scoreboard_if #(
    parameter int REG_AW     = 5,
    parameter int NUM_SRC    = 2,
    parameter int PEND_DEPTH = 4
);
    logic [NUM_SRC*REG_AW-1:0]        iIdRegSrc;
    logic [NUM_SRC-1:0]               iIdSrcValid;
    logic [REG_AW-1:0]                iIdRegRd;
    logic                             iIdRegWrite;
    logic                             iIdLongOp;
    logic [NUM_SRC*REG_AW-1:0]        iExRegSrc;
    logic [REG_AW-1:0]                iExRegRd;
    logic                             iExMemRead;
    logic                             iExLongIssue;
    logic [REG_AW-1:0]                iMemRegRd;
    logic                             iMemRegWrite;
    logic [REG_AW-1:0]                iWbRegRd;
    logic                             iWbRegWrite;
    logic                             iLongWbValid;
    logic [REG_AW-1:0]                iLongWbRd;
    logic [2*NUM_SRC-1:0]             oForwardCmd;
    logic                             oStall;
    logic [$clog2(PEND_DEPTH+1)-1:0]  oPendCount;
    logic                             oTimeoutErr;

    modport master (
        output iIdRegSrc, iIdSrcValid, iIdRegRd, iIdRegWrite, iIdLongOp,
               iExRegSrc, iExRegRd, iExMemRead, iExLongIssue,
               iMemRegRd, iMemRegWrite, iWbRegRd, iWbRegWrite,
               iLongWbValid, iLongWbRd,
        input  oForwardCmd, oStall, oPendCount, oTimeoutErr
    );

    modport slave (
        input  iIdRegSrc, iIdSrcValid, iIdRegRd, iIdRegWrite, iIdLongOp,
               iExRegSrc, iExRegRd, iExMemRead, iExLongIssue,
               iMemRegRd, iMemRegWrite, iWbRegRd, iWbRegWrite,
               iLongWbValid, iLongWbRd,
        output oForwardCmd, oStall, oPendCount, oTimeoutErr
    );
endinterface

// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding and hazard unit for the 5-stage pipeline.
// It computes the EX operand forward selects, and it raises the ID stall for four cases:
// load-use, RAW on a pending long op, WAW on a pending long op, and a full scoreboard.
// The scoreboard holds PEND_DEPTH destinations of long ops that were issued from EX.
// An entry is retired when the long unit writes back that destination.
// Optional feature: macro FWD_TIMEOUT_EN. When it is defined, an entry that reaches
// TIMEOUT_CYC-1 cycles of age is force-cleared, and oTimeoutErr pulses for one cycle.
module fwd_hazard_scoreboard #(
    parameter int REG_AW      = 5,
    parameter int NUM_SRC     = 2,
    parameter int PEND_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input logic              iClk,
    input logic              iReset,
    fwd_hazard_scoreboard_if.slave bus
);
    localparam int CW = $clog2(PEND_DEPTH + 1);

    logic [PEND_DEPTH-1:0]             valid_q, valid_d;
    logic [PEND_DEPTH-1:0][REG_AW-1:0] rd_q, rd_d;
    logic [PEND_DEPTH-1:0]             retire_hit;
    logic                              retire_found;
    logic                              alloc_done;
    logic [CW-1:0]                     pend_count;
    logic [2*NUM_SRC-1:0]              fwd_cmd;
    logic                              load_use, raw_hit, waw_hit, full_hit;

`ifdef FWD_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] AGE_LIM = TW'(TIMEOUT_CYC - 1);
    logic [PEND_DEPTH-1:0][TW-1:0]     age_q, age_d;
    logic                              timeout_err_q, timeout_err_d;
`endif

    // Select the single lowest-index valid entry that this cycle's long writeback retires.
    always_comb begin
        retire_hit   = '0;
        retire_found = 1'b0;
        for (int i = 0; i < PEND_DEPTH; i++) begin
            if (!retire_found && bus.iLongWbValid && valid_q[i] && rd_q[i] == bus.iLongWbRd) begin
                retire_hit[i] = 1'b1;
                retire_found  = 1'b1;
            end
        end
    end

    // Count the valid entries. The count therefore changes only at the clock edge.
    always_comb begin
        pend_count = '0;
        for (int i = 0; i < PEND_DEPTH; i++) begin
            pend_count = pend_count + CW'(valid_q[i]);
        end
    end

    // Build the per-source forward selects. MEM has priority over WB. Register 0 never matches.
    always_comb begin
        fwd_cmd = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (bus.iMemRegWrite && bus.iMemRegRd != '0 &&
                bus.iMemRegRd == bus.iExRegSrc[k*REG_AW +: REG_AW]) begin
                fwd_cmd[2*k +: 2] = 2'b01;
            end else if (bus.iWbRegWrite && bus.iWbRegRd != '0 &&
                         bus.iWbRegRd == bus.iExRegSrc[k*REG_AW +: REG_AW]) begin
                fwd_cmd[2*k +: 2] = 2'b10;
            end
        end
    end

    // Compute the stall terms. The entry that retires this cycle is excluded, because the
    // regfile is write-through and ID reads the new value.
    always_comb begin
        load_use = 1'b0;
        raw_hit  = 1'b0;
        waw_hit  = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (bus.iIdSrcValid[k]) begin
                if (bus.iExMemRead && bus.iExRegRd != '0 &&
                    bus.iExRegRd == bus.iIdRegSrc[k*REG_AW +: REG_AW]) begin
                    load_use = 1'b1;
                end
                if (bus.iIdRegSrc[k*REG_AW +: REG_AW] != '0) begin
                    for (int i = 0; i < PEND_DEPTH; i++) begin
                        if (valid_q[i] && !retire_hit[i] &&
                            rd_q[i] == bus.iIdRegSrc[k*REG_AW +: REG_AW]) begin
                            raw_hit = 1'b1;
                        end
                    end
                end
            end
        end
        if (bus.iIdRegWrite && bus.iIdRegRd != '0) begin
            for (int i = 0; i < PEND_DEPTH; i++) begin
                if (valid_q[i] && !retire_hit[i] && rd_q[i] == bus.iIdRegRd) begin
                    waw_hit = 1'b1;
                end
            end
        end
        // A retirement in the same cycle does not free a slot for this check.
        full_hit = bus.iIdLongOp &&
                   ((int'(pend_count) + int'(bus.iExLongIssue)) >= PEND_DEPTH);
    end

    // Compute the next scoreboard state. Retire runs first, then the optional timeout, then
    // the allocate. An entry that is freed this cycle can therefore be reused in the same cycle.
    always_comb begin
        valid_d    = valid_q & ~retire_hit;
        rd_d       = rd_q;
        alloc_done = 1'b0;
`ifdef FWD_TIMEOUT_EN
        age_d         = age_q;
        timeout_err_d = 1'b0;
        for (int i = 0; i < PEND_DEPTH; i++) begin
            if (valid_d[i]) begin
                if (age_q[i] == AGE_LIM) begin
                    valid_d[i]    = 1'b0;
                    timeout_err_d = 1'b1;
                end else begin
                    age_d[i] = age_q[i] + TW'(1);
                end
            end
        end
`endif
        if (bus.iExLongIssue && bus.iExRegRd != '0) begin
            for (int i = 0; i < PEND_DEPTH; i++) begin
                if (!alloc_done && !valid_d[i]) begin
                    valid_d[i] = 1'b1;
                    rd_d[i]    = bus.iExRegRd;
`ifdef FWD_TIMEOUT_EN
                    age_d[i]   = '0;
`endif
                    alloc_done = 1'b1;
                end
            end
        end
    end

    // Scoreboard registers. An asynchronous reset discards every entry immediately.
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            valid_q <= '0;
            rd_q    <= '0;
        end else begin
            valid_q <= valid_d;
            rd_q    <= rd_d;
        end
    end

`ifdef FWD_TIMEOUT_EN
    // Age counters and the registered one-cycle timeout pulse.
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            age_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            age_q         <= age_d;
            timeout_err_q <= timeout_err_d;
        end
    end
    assign bus.oTimeoutErr = timeout_err_q;
`else
    assign bus.oTimeoutErr = 1'b0;
`endif

    assign bus.oForwardCmd = fwd_cmd;
    assign bus.oStall      = load_use | raw_hit | waw_hit | full_hit;
    assign bus.oPendCount  = pend_count;
endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Directed testbench for fwd_hazard_scoreboard. The sequence of steps is linear, and every
// expected value is computed by hand. Inputs change 1 time unit after a rising edge.
// Combinational outputs are checked 1 unit after the inputs change.
module tb_fwd_hazard_scoreboard;
    localparam int REG_AW     = 5;
    localparam int NUM_SRC    = 2;
    localparam int PEND_DEPTH = 4;
`ifdef FWD_TIMEOUT_EN
    localparam int TO_CYC     = 8;
`else
    localparam int TO_CYC     = 64;
`endif

    logic iClk;
    logic iReset;
    int   checks;
    int   errors;

    fwd_hazard_scoreboard_if #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .PEND_DEPTH(PEND_DEPTH)) bus ();

    fwd_hazard_scoreboard #(
        .REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .PEND_DEPTH(PEND_DEPTH), .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .iClk   (iClk),
        .iReset (iReset),
        .bus    (bus)
    );

    // Clock and reset.
    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // Drivers.
    task automatic clr_inputs();
        bus.iIdRegSrc    = '0;
        bus.iIdSrcValid  = '0;
        bus.iIdRegRd     = '0;
        bus.iIdRegWrite  = 1'b0;
        bus.iIdLongOp    = 1'b0;
        bus.iExRegSrc    = '0;
        bus.iExRegRd     = '0;
        bus.iExMemRead   = 1'b0;
        bus.iExLongIssue = 1'b0;
        bus.iMemRegRd    = '0;
        bus.iMemRegWrite = 1'b0;
        bus.iWbRegRd     = '0;
        bus.iWbRegWrite  = 1'b0;
        bus.iLongWbValid = 1'b0;
        bus.iLongWbRd    = '0;
    endtask

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic issue(input logic [REG_AW-1:0] rd);
        bus.iExLongIssue = 1'b1;
        bus.iExRegRd     = rd;
        step();
        bus.iExLongIssue = 1'b0;
        bus.iExRegRd     = '0;
    endtask

    task automatic retire(input logic [REG_AW-1:0] rd);
        bus.iLongWbValid = 1'b1;
        bus.iLongWbRd    = rd;
        step();
        bus.iLongWbValid = 1'b0;
        bus.iLongWbRd    = '0;
    endtask

    // Comparison point.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        iReset = 1'b0;
        clr_inputs();
        #2 iReset = 1'b1;
        settle();
        check("rst_count",   32'(bus.oPendCount), 32'd0);
        check("rst_stall",   32'(bus.oStall), 32'd0);
        check("rst_fwd",     32'(bus.oForwardCmd), 32'd0);
        check("rst_timeout", 32'(bus.oTimeoutErr), 32'd0);
        step();
        step();
        iReset = 1'b0;
        step();

        // Forwarding priority and the register-0 exclusion.
        bus.iMemRegRd = 5'd5; bus.iMemRegWrite = 1'b1;
        bus.iWbRegRd  = 5'd5; bus.iWbRegWrite  = 1'b1;
        bus.iExRegSrc = {5'd0, 5'd5};
        settle();
        check("fwd_mem_over_wb", 32'(bus.oForwardCmd), 32'h1);
        bus.iMemRegWrite = 1'b0;
        settle();
        check("fwd_wb", 32'(bus.oForwardCmd), 32'h2);
        bus.iMemRegWrite = 1'b1; bus.iWbRegRd = 5'd6; bus.iExRegSrc = {5'd6, 5'd5};
        settle();
        check("fwd_mem_src0_wb_src1", 32'(bus.oForwardCmd), 32'h9);
        bus.iMemRegRd = 5'd0; bus.iWbRegRd = 5'd0; bus.iExRegSrc = '0;
        settle();
        check("fwd_r0", 32'(bus.oForwardCmd), 32'h0);
        clr_inputs();

        // Load-use stall for one cycle, followed by the MEM forward.
        bus.iExMemRead = 1'b1; bus.iExRegRd = 5'd7;
        bus.iIdRegSrc = {5'd7, 5'd0}; bus.iIdSrcValid = 2'b01;
        settle();
        check("lu_invalid_src", 32'(bus.oStall), 32'd0);
        bus.iIdSrcValid = 2'b10;
        settle();
        check("lu_stall", 32'(bus.oStall), 32'd1);
        step();
        clr_inputs();
        bus.iMemRegRd = 5'd7; bus.iMemRegWrite = 1'b1; bus.iExRegSrc = {5'd7, 5'd0};
        settle();
        check("lu_release", 32'(bus.oStall), 32'd0);
        check("lu_fwd_mem", 32'(bus.oForwardCmd), 32'h4);
        clr_inputs();

        // A rd=0 issue is never tracked.
        issue(5'd0);
        check("issue_r0_count", 32'(bus.oPendCount), 32'd0);

        // RAW stall on a pending long op, released by a same-cycle retire.
        issue(5'd9);
        check("raw_count1", 32'(bus.oPendCount), 32'd1);
        bus.iIdRegSrc = {5'd0, 5'd9}; bus.iIdSrcValid = 2'b01;
        settle();
        check("raw_stall", 32'(bus.oStall), 32'd1);
        step();
        check("raw_stall_held", 32'(bus.oStall), 32'd1);
        bus.iLongWbValid = 1'b1; bus.iLongWbRd = 5'd9;
        settle();
        check("raw_retire_drop", 32'(bus.oStall), 32'd0);
        check("raw_count_pre", 32'(bus.oPendCount), 32'd1);
        step();
        bus.iLongWbValid = 1'b0; bus.iLongWbRd = '0;
        settle();
        check("raw_count0", 32'(bus.oPendCount), 32'd0);
        check("raw_clear_stall", 32'(bus.oStall), 32'd0);
        clr_inputs();

        // Full scoreboard.
        issue(5'd1);
        issue(5'd2);
        bus.iIdLongOp = 1'b1; bus.iExLongIssue = 1'b1; bus.iExRegRd = 5'd3;
        settle();
        check("full_2p1", 32'(bus.oStall), 32'd0);
        step();
        bus.iExRegRd = 5'd4;
        settle();
        check("full_3p1", 32'(bus.oStall), 32'd1);
        step();
        bus.iExLongIssue = 1'b0; bus.iExRegRd = '0;
        settle();
        check("full_count4", 32'(bus.oPendCount), 32'd4);
        check("full_stall", 32'(bus.oStall), 32'd1);
        bus.iLongWbValid = 1'b1; bus.iLongWbRd = 5'd2;
        bus.iExLongIssue = 1'b1; bus.iExRegRd = 5'd6;
        settle();
        check("full_no_credit", 32'(bus.oStall), 32'd1);
        step();
        bus.iExLongIssue = 1'b0; bus.iExRegRd = '0; bus.iIdLongOp = 1'b0;
        settle();
        check("swap_count4", 32'(bus.oPendCount), 32'd4);
        retire(5'd2);
        check("retire_nomatch", 32'(bus.oPendCount), 32'd4);
        bus.iIdRegSrc = {5'd0, 5'd6}; bus.iIdSrcValid = 2'b01;
        settle();
        check("raw_on_swapped", 32'(bus.oStall), 32'd1);
        bus.iIdRegSrc = {5'd0, 5'd2};
        settle();
        check("no_raw_retired", 32'(bus.oStall), 32'd0);
        clr_inputs();
        retire(5'd1);
        retire(5'd3);
        retire(5'd4);
        retire(5'd6);
        check("drain_count0", 32'(bus.oPendCount), 32'd0);

        // WAW stall, then an asynchronous reset in the middle of the stall.
        issue(5'd3);
        bus.iIdRegWrite = 1'b1; bus.iIdRegRd = 5'd3; bus.iIdSrcValid = 2'b00;
        settle();
        check("waw_stall", 32'(bus.oStall), 32'd1);
        #1 iReset = 1'b1;
        settle();
        check("async_rst_stall", 32'(bus.oStall), 32'd0);
        check("async_rst_count", 32'(bus.oPendCount), 32'd0);
        step();
        iReset = 1'b0;
        clr_inputs();
        step();
        check("no_timeout_default", 32'(bus.oTimeoutErr), 32'd0);

`ifdef FWD_TIMEOUT_EN
        // Forced clear after TO_CYC cycles without a retire.
        issue(5'd4);
        for (int c = 0; c < TO_CYC - 1; c++) step();
        check("to_before_count", 32'(bus.oPendCount), 32'd1);
        check("to_before_err", 32'(bus.oTimeoutErr), 32'd0);
        step();
        check("to_count0", 32'(bus.oPendCount), 32'd0);
        check("to_pulse", 32'(bus.oTimeoutErr), 32'd1);
        step();
        check("to_pulse_end", 32'(bus.oTimeoutErr), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
